mram_host_serializer: RTL
=========================

// Module: mram_host_serializer
// PURPOSE
// Host-side front end for the serial MRAM integration top. Accepts parallel
// read/write commands (single or burst) over a valid/ready handshake. Serialises
// address, burst length and write data onto the one-bit lines that feed the
// integration top, and drives its burst/mode/read_write_sel controls.
// Deserialises the returned serial read data into parallel 16-bit responses.
// PARAMETERS
// ADDR_W     20  address width, bits shifted on addr_ser
// DATA_W     16  data width, bits on data_ser / ser_rdata
// LEN_W      8   burst length width, bits shifted on burst_len_ser
// ACCESS_CYC 4   cycles read_write_sel is held per beat (>=1)
// PORTS
// clk            in   1       system clock
// rst            in   1       asynchronous active-low reset
// cmd_valid      in   1       command offered
// cmd_ready      out  1       command accepted when valid&ready
// cmd_write      in   1       1=write, 0=read
// cmd_burst      in   1       1=burst, 0=single transfer
// cmd_addr       in   ADDR_W  start address
// cmd_len        in   LEN_W   burst beats (ignored if single)
// cmd_wdata      in   DATA_W  write data, beat 0
// wdata_valid    in   1       write data for beats 1..N-1 offered
// wdata_ready    out  1       beat data accepted when valid&ready
// wdata          in   DATA_W  write data, beats 1..N-1
// rsp_valid      out  1       one-cycle pulse, rsp_data valid
// rsp_data       out  DATA_W  read beat data
// busy           out  1       high in any state but IDLE
// burst_en       out  1       enables downstream burst controller
// mode_sel       out  1       0=single, 1=burst
// burst_len_ser  out  1       serial burst length, MSB first
// addr_ser       out  1       serial address, MSB first
// data_ser       out  1       serial write data, MSB first
// read_write_sel out  3       RW_IDLE=3'b000, RW_WRITE=3'b001, RW_READ=3'b010
// ser_rdata      in   1       serial read data from downstream PTS, MSB first
// BEHAVIOUR
// - Reset (rst=0, async): state IDLE; all outputs 0, read_write_sel=RW_IDLE; in-flight command discarded.
// - IDLE: cmd_ready=1. On accept, latch all cmd_* fields -> LOAD. Beats N=1 if single, else max(cmd_len,1).
// - LOAD (ADDR_W cycles): addr_ser bit ADDR_W-1-k in cycle k.
//   burst_len_ser carries N over the last LEN_W cycles, else 0.
//   Write: data_ser carries cmd_wdata over the last DATA_W cycles, else 0.
//   burst_en=mode_sel=cmd_burst from LOAD until return to IDLE.
// - ACCESS (ACCESS_CYC cycles): read_write_sel=RW_WRITE/RW_READ; RW_IDLE otherwise.
// - Read: ACCESS -> CAPTURE (DATA_W cycles), shift ser_rdata MSB first.
//   rsp_valid pulses the cycle after the last bit; no backpressure.
// - Beat counter decrements per completed beat; at 0 -> IDLE.
//   Read, beats left: CAPTURE -> ACCESS.
//   Write, beats left: ACCESS -> WDATA. wdata_ready=1 until wdata_valid.
//   Then -> WSHIFT (DATA_W cycles on data_ser) -> ACCESS.
//   Stall in WDATA indefinitely; no access issued while stalled.
// - Downstream increments addresses; the address is shifted once per command only.
// - cmd_ready=0 outside IDLE; min one IDLE cycle between commands.
// - Counters sized $clog2(max(ADDR_W,ACCESS_CYC)+1); beat counter LEN_W bits.
// STRUCTURE
// - mram_host_pkg: state enum (IDLE,LOAD,ACCESS,CAPTURE,WDATA,WSHIFT), RW_* codes, default widths.
// - Sub-module mram_ser_shift: parametric shift register, load/shift-out MSB and shift-in LSB.
//   Instantiated for address, length, write data and read capture.
// TESTING
// - Single write 0x0A5C3/0xBEEF -> addr_ser 0000_1010_0101_1100_0011 over 20 cycles.
//   data_ser 0xBEEF in cycles 4..19; RW_WRITE for 4 cycles; cmd_ready back 1.
// - Single read 0x00010, ser_rdata drives 0x1234 in CAPTURE -> one rsp_valid, rsp_data=0x1234.
// - Burst read len 4 -> burst_len_ser 0x04 in LOAD cycles 12..19; burst_en=1 throughout.
//   4 RW_READ windows, 4 rsp pulses.
// - Burst write len 3, wdata_valid delayed 5 cycles on beat 2 -> stall in WDATA.
//   RW_IDLE during stall; 3 RW_WRITE windows total.
// - Burst with cmd_len=0 -> executes exactly 1 beat, burst_len_ser carries 0x01.
// - rst low mid-LOAD -> outputs 0 immediately, no rsp; after release cmd_ready=1 next cycle.

Source files
------------

// File: rtl/mram_host_pkg.sv
// rtl/mram_host_pkg.sv - Shared states, read/write select codes and default widths for the MRAM host serializer
package mram_host_pkg;

    localparam int ADDR_W_DEF     = 20;
    localparam int DATA_W_DEF     = 16;
    localparam int LEN_W_DEF      = 8;
    localparam int ACCESS_CYC_DEF = 4;

    localparam logic [2:0] RW_IDLE  = 3'b000;
    localparam logic [2:0] RW_WRITE = 3'b001;
    localparam logic [2:0] RW_READ  = 3'b010;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ACCESS  = 3'd2,
        CAPTURE = 3'd3,
        WDATA   = 3'd4,
        WSHIFT  = 3'd5
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mram_ser_shift.sv
// rtl/mram_ser_shift.sv - Parallel-load shift register, serial out at the MSB and serial in at the LSB
module mram_ser_shift #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         shift_en,
    input  logic         shift_in,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift_en) begin
            q <= {q[W-2:0], shift_in};
        end
    end

endmodule

// File: rtl/mram_host_serializer.sv
// rtl/mram_host_serializer.sv - Parallel command front end serialising onto the MRAM integration top
module mram_host_serializer
    import mram_host_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int ACCESS_CYC = ACCESS_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic              cmd_burst,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [DATA_W-1:0] wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              burst_en,
    output logic              mode_sel,
    output logic              burst_len_ser,
    output logic              addr_ser,
    output logic              data_ser,
    output logic [2:0]        read_write_sel,
    input  logic              ser_rdata
);

    localparam int CNT_W = $clog2(max2(max2(ADDR_W, ACCESS_CYC), DATA_W) + 1);
    localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] ACCESS_LAST = CNT_W'(ACCESS_CYC - 1);
    localparam logic [CNT_W-1:0] WORD_LAST   = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LEN_START   = CNT_W'(ADDR_W - LEN_W);
    localparam logic [CNT_W-1:0] WD_START    = CNT_W'(ADDR_W - DATA_W);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  beats_q;
    logic              write_q;
    logic              burst_q;
    logic              ready_en_q;
    logic              rsp_valid_q;

    logic              cmd_accept;
    logic              wdata_accept;
    logic              beat_done;
    logic              last_beat;
    logic              load_last;
    logic              access_last;
    logic              word_last;
    logic [LEN_W-1:0]  n_beats;

    logic [ADDR_W-1:0] addr_sr;
    logic [LEN_W-1:0]  len_sr;
    logic [DATA_W-1:0] wd_sr;
    logic [DATA_W-1:0] cap_sr;
    logic [DATA_W-1:0] wd_load;
    logic              wd_load_en;
    logic              addr_shift;
    logic              len_shift;
    logic              wd_shift;
    logic              cap_shift;
    logic              unused_bits;

    assign cmd_accept   = cmd_valid && cmd_ready;
    assign wdata_accept = (state_q == WDATA) && wdata_valid;
    assign load_last    = (cnt_q == LOAD_LAST);
    assign access_last  = (cnt_q == ACCESS_LAST);
    assign word_last    = (cnt_q == WORD_LAST);
    assign last_beat    = (beats_q == LEN_W'(1));
    assign beat_done    = ((state_q == ACCESS) && access_last && write_q) ||
                          ((state_q == CAPTURE) && word_last);

    // A burst with a zero length still performs one beat.
    assign n_beats = (cmd_burst && (cmd_len != '0)) ? cmd_len : LEN_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_accept) state_d = LOAD;
            end
            LOAD: begin
                if (load_last) state_d = ACCESS;
            end
            ACCESS: begin
                if (access_last) begin
                    if (!write_q)      state_d = CAPTURE;
                    else if (last_beat) state_d = IDLE;
                    else               state_d = WDATA;
                end
            end
            CAPTURE: begin
                if (word_last) state_d = last_beat ? IDLE : ACCESS;
            end
            WDATA: begin
                if (wdata_valid) state_d = WSHIFT;
            end
            WSHIFT: begin
                if (word_last) state_d = ACCESS;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready      = 1'b0;
        busy           = 1'b0;
        burst_en       = 1'b0;
        mode_sel       = 1'b0;
        read_write_sel = RW_IDLE;
        wdata_ready    = 1'b0;
        addr_ser       = 1'b0;
        burst_len_ser  = 1'b0;
        data_ser       = 1'b0;
        addr_shift     = 1'b0;
        len_shift      = 1'b0;
        wd_shift       = 1'b0;
        cap_shift      = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready = ready_en_q;
            end
            LOAD: begin
                // Length and write data are right-aligned to the end of the address phase.
                addr_shift    = 1'b1;
                addr_ser      = addr_sr[ADDR_W-1];
                len_shift     = (cnt_q >= LEN_START);
                burst_len_ser = len_shift && len_sr[LEN_W-1];
                wd_shift      = write_q && (cnt_q >= WD_START);
                data_ser      = wd_shift && wd_sr[DATA_W-1];
            end
            ACCESS: begin
                read_write_sel = write_q ? RW_WRITE : RW_READ;
            end
            CAPTURE: begin
                cap_shift = 1'b1;
            end
            WDATA: begin
                wdata_ready = 1'b1;
            end
            WSHIFT: begin
                wd_shift = 1'b1;
                data_ser = wd_sr[DATA_W-1];
            end
            default: ;
        endcase
        if (state_q != IDLE) begin
            busy     = 1'b1;
            burst_en = burst_q;
            mode_sel = burst_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            beats_q     <= '0;
            write_q     <= 1'b0;
            burst_q     <= 1'b0;
            ready_en_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            // Holds cmd_ready low for the first cycle after reset release.
            ready_en_q  <= 1'b1;
            rsp_valid_q <= (state_q == CAPTURE) && word_last;
            if ((state_d != state_q) || (state_q == IDLE) || (state_q == WDATA)) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (cmd_accept) begin
                beats_q <= n_beats;
                write_q <= cmd_write;
                burst_q <= cmd_burst;
            end else if (beat_done) begin
                beats_q <= beats_q - 1'b1;
            end
        end
    end

    assign wd_load_en = cmd_accept || wdata_accept;
    assign wd_load    = (state_q == WDATA) ? wdata : cmd_wdata;

    mram_ser_shift #(.W(ADDR_W)) u_addr_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (cmd_accept),
        .load_data (cmd_addr),
        .shift_en  (addr_shift),
        .shift_in  (1'b0),
        .q         (addr_sr)
    );

    mram_ser_shift #(.W(LEN_W)) u_len_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (cmd_accept),
        .load_data (n_beats),
        .shift_en  (len_shift),
        .shift_in  (1'b0),
        .q         (len_sr)
    );

    mram_ser_shift #(.W(DATA_W)) u_wdata_shift (
        .clk       (clk),
        .rst       (rst),
        .load      (wd_load_en),
        .load_data (wd_load),
        .shift_en  (wd_shift),
        .shift_in  (1'b0),
        .q         (wd_sr)
    );

    mram_ser_shift #(.W(DATA_W)) u_rdata_capture (
        .clk       (clk),
        .rst       (rst),
        .load      (1'b0),
        .load_data ('0),
        .shift_en  (cap_shift),
        .shift_in  (ser_rdata),
        .q         (cap_sr)
    );

    // The capture register holds the word until the next CAPTURE, which is at least one access window away.
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = cap_sr;
    assign unused_bits = ^{addr_sr[ADDR_W-2:0], len_sr[LEN_W-2:0], wd_sr[DATA_W-2:0]};

endmodule
